pipe_wb_reg: RTL and testbench
==============================

PIPE_WB_REG -- requirements
Module: pipe_wb_reg

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning number of write-back lanes (legal 1..4).
REQ-002 SHALL have parameter STAGE, default 4, meaning index of this register's own stall bit.
REQ-003 SHALL have parameter STALL_W, default 6, meaning stall vector width.
REQ-004 SHALL have parameter CNT_W, default 16, meaning bubble counter width.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low (RstEnable = 0).
REQ-007 SHALL have port stall  input  STALL_W  pipeline stall vector, 1 = Stop.
REQ-008 SHALL have port flush  input  1  synchronous squash of this stage.
REQ-009 SHALL have port cnt_clr  input  1  synchronous clear of bubble counter.
REQ-010 SHALL have port in_wd  input  LANES*5  per-lane destination register, lane i at bits [5i+4:5i].
REQ-011 SHALL have port in_wreg  input  LANES  per-lane write enable.
REQ-012 SHALL have port in_wdata  input  LANES*32  per-lane write data.
REQ-013 SHALL have ports in_hi, in_lo  input  32 each  HI/LO values; in_whilo  input  1  HI/LO write enable.
REQ-014 SHALL have outputs out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo with widths matching their inputs, registered.
REQ-015 SHALL have port out_waw  output  1  registered flag: two lanes of the held bundle write the same nonzero register.
REQ-016 SHALL have port bubble_cnt  output  CNT_W  count of bubble cycles inserted.

Function
REQ-017 SHALL evaluate per rising edge, priority: flush > bubble > hold > advance.
REQ-018 SHALL, on flush = 1, load NOP: all out_wd = 0, out_wreg = 0, out_wdata = 0, out_hi = out_lo = 0, out_whilo = 0, out_waw = 0.
REQ-019 SHALL define bubble as stall[STAGE] = 1 and downstream stall[STAGE+1] = 0; when STAGE = STALL_W-1 downstream SHALL be taken as 0.
REQ-020 SHALL, on bubble, load NOP exactly as REQ-018 and increment bubble_cnt.
REQ-021 SHALL, on hold (stall[STAGE] = 1, downstream = 1), retain all outputs including out_waw unchanged.
REQ-022 SHALL, on advance (stall[STAGE] = 0), capture all inputs with latency of exactly one cycle.
REQ-023 SHALL, on advance, set out_waw = 1 iff some lanes i < j have in_wreg[i] = in_wreg[j] = 1 and in_wd[i] = in_wd[j] != 0; else 0.
REQ-024 SHALL, when LANES = 1, tie out_waw to 0.
REQ-025 SHALL saturate bubble_cnt at all-ones (no wrap).
REQ-026 SHALL, when cnt_clr = 1, load bubble_cnt = 0 that cycle, overriding a simultaneous increment.
REQ-027 SHALL treat flush cycles as not bubbles (no count), even if stall bits also form a bubble.

Reset
REQ-028 SHALL, while rst = 0, asynchronously force all outputs to 0 (NOP bundle, out_waw = 0, bubble_cnt = 0) regardless of clk, stall or flush.
REQ-029 SHALL, on rst deassertion, resume at the next rising edge with no extra idle cycle.
REQ-030 SHALL, on reset asserted mid-hold, discard the held bundle.

Structure
REQ-031 SHALL take RegBus/RegAddrBus widths, Stop/NoStop, WriteEnable/Disable, ZeroWord, NOPRegAddr and RstEnable from the shared define file.
REQ-032 SHALL implement the WAW compare as sub-module waw_detect (combinational, LANES-parametrised); all state stays in pipe_wb_reg.
REQ-033 SHALL reject LANES outside 1..4 or STAGE >= STALL_W at elaboration.

Verification
REQ-034 SHALL cover advance: stall = 0, lane0 wd = 3, wreg = 1, wdata = 0x1234 -> next cycle out_wd[4:0] = 3, out_wdata[31:0] = 0x1234, out_wreg[0] = 1.
REQ-035 SHALL cover bubble: stall = 6'b010000 for 3 cycles -> outputs NOP each cycle, bubble_cnt = 3.
REQ-036 SHALL cover hold: load bundle, then stall = 6'b110000 for 5 cycles -> outputs unchanged, bubble_cnt unchanged.
REQ-037 SHALL cover WAW: lanes 0, 1 both wreg = 1, wd = 7 -> out_waw = 1; both wd = 0 -> out_waw = 0.
REQ-038 SHALL cover priority: flush = 1 with stall = 6'b010000 and cnt_clr = 0 -> NOP, bubble_cnt unchanged; cnt_clr = 1 with bubble -> bubble_cnt = 0.
REQ-039 SHALL cover reset: rst low between clock edges mid-hold -> outputs 0 immediately; CNT_W = 2, 5 bubbles -> bubble_cnt = 3.

Source files
------------

// File: rtl/pipe_wb_reg_pkg.sv
// Shared definitions for the write-back pipeline register.
// Holds the bus widths and encodings that used to come from the shared define file.
// It also holds the per-edge action encoding and the helper that selects that action.
package pipe_wb_reg_pkg;

    localparam int          RegBus       = 32;
    localparam int          RegAddrBus   = 5;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        RstEnable    = 1'b0;

    // Action taken by the register at a rising edge.
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } wb_act_e;

    // Selects the action. Flush has the highest priority.
    // Our stage stalled while the downstream stage keeps moving inserts a bubble.
    // Both stages stalled holds the register.
    function automatic wb_act_e wb_action(input logic flush, input logic own, input logic down);
        if (flush)
            return ACT_FLUSH;
        else if (own == Stop && down == NoStop)
            return ACT_BUBBLE;
        else if (own == Stop)
            return ACT_HOLD;
        else
            return ACT_ADVANCE;
    endfunction

endpackage

// File: rtl/pipe_wb_reg_waw.sv
// waw_detect: combinational write-after-write detector for one write-back bundle.
// Ports:
//   wd   : per-lane destination register; lane i occupies bits [5i+4:5i].
//   wreg : per-lane write enable.
//   waw  : 1 when two enabled lanes target the same nonzero register.
// With LANES = 1 there are no lane pairs, so waw stays at 0.
module waw_detect
    import pipe_wb_reg_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic [LANES*RegAddrBus-1:0] wd,
    input  logic [LANES-1:0]            wreg,
    output logic                        waw
);

    always_comb begin
        waw = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (wreg[i] == WriteEnable && wreg[j] == WriteEnable &&
                    wd[i*RegAddrBus +: RegAddrBus] == wd[j*RegAddrBus +: RegAddrBus] &&
                    wd[i*RegAddrBus +: RegAddrBus] != NOPRegAddr)
                    waw = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_wb_reg.sv
// pipe_wb_reg: multi-lane write-back pipeline register with flush, bubble and hold.
// It also flags a write-after-write hazard and counts the bubbles it inserts.
// Ports:
//   clk, rst       : clock and asynchronous active-low reset.
//   stall          : pipeline stall vector; STAGE is this register's bit.
//   flush          : synchronous squash of this stage.
//   cnt_clr        : synchronous clear of bubble_cnt.
//   in_*           : write-back bundle from the previous stage.
//   out_*          : registered bundle.
//   out_waw        : registered flag, set when two lanes of the held bundle hit the same nonzero register.
//   bubble_cnt     : saturating count of inserted bubbles.
module pipe_wb_reg
    import pipe_wb_reg_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int STAGE   = 4,
    parameter int STALL_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [STALL_W-1:0]          stall,
    input  logic                        flush,
    input  logic                        cnt_clr,
    input  logic [LANES*RegAddrBus-1:0] in_wd,
    input  logic [LANES-1:0]            in_wreg,
    input  logic [LANES*RegBus-1:0]     in_wdata,
    input  logic [RegBus-1:0]           in_hi,
    input  logic [RegBus-1:0]           in_lo,
    input  logic                        in_whilo,
    output logic [LANES*RegAddrBus-1:0] out_wd,
    output logic [LANES-1:0]            out_wreg,
    output logic [LANES*RegBus-1:0]     out_wdata,
    output logic [RegBus-1:0]           out_hi,
    output logic [RegBus-1:0]           out_lo,
    output logic                        out_whilo,
    output logic                        out_waw,
    output logic [CNT_W-1:0]            bubble_cnt
);

    generate
        if (LANES < 1 || LANES > 4 || STAGE >= STALL_W) begin : g_bad_param
            $error("pipe_wb_reg: LANES must be 1..4 and STAGE < STALL_W");
        end
    endgenerate

    // The last stage has no downstream stage, so downstream is treated as never stalled.
    logic down;
    generate
        if (STAGE == STALL_W - 1) begin : g_last
            assign down = NoStop;
        end else begin : g_mid
            assign down = stall[STAGE+1];
        end
    endgenerate

    // This register does not use the stall bits that belong to other stages.
    logic stall_unused;
    assign stall_unused = ^stall;

    logic    waw_next;
    wb_act_e act;

    waw_detect #(.LANES(LANES)) u_waw (
        .wd   (in_wd),
        .wreg (in_wreg),
        .waw  (waw_next)
    );

    always_comb begin
        act = wb_action(flush, stall[STAGE], down);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            out_wd     <= '0;
            out_wreg   <= '0;
            out_wdata  <= '0;
            out_hi     <= ZeroWord;
            out_lo     <= ZeroWord;
            out_whilo  <= WriteDisable;
            out_waw    <= 1'b0;
            bubble_cnt <= '0;
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    out_wd    <= '0;
                    out_wreg  <= '0;
                    out_wdata <= '0;
                    out_hi    <= ZeroWord;
                    out_lo    <= ZeroWord;
                    out_whilo <= WriteDisable;
                    out_waw   <= 1'b0;
                end
                ACT_ADVANCE: begin
                    out_wd    <= in_wd;
                    out_wreg  <= in_wreg;
                    out_wdata <= in_wdata;
                    out_hi    <= in_hi;
                    out_lo    <= in_lo;
                    out_whilo <= in_whilo;
                    out_waw   <= waw_next;
                end
                default: ;  // hold: keep everything, including out_waw
            endcase

            // A clear wins over a same-cycle increment. A flush is never counted as a bubble.
            if (cnt_clr)
                bubble_cnt <= '0;
            else if (act == ACT_BUBBLE && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_wb_reg.sv
// Self-checking bench for pipe_wb_reg. It drives two instances from the same inputs:
//   instance 0: STAGE=4, CNT_W=16 (mid-pipe stage).
//   instance 1: STAGE=5, CNT_W=2  (last stage, small saturating counter).
// A behavioural model per instance predicts every output.
module tb_pipe_wb_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush, cnt_clr;
    logic [9:0]  in_wd;
    logic [1:0]  in_wreg;
    logic [63:0] in_wdata;
    logic [31:0] in_hi, in_lo;
    logic        in_whilo;

    logic [9:0]  o_wd    [2];
    logic [1:0]  o_wreg  [2];
    logic [63:0] o_wdata [2];
    logic [31:0] o_hi    [2];
    logic [31:0] o_lo    [2];
    logic        o_whilo [2];
    logic        o_waw   [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int errs = 0;
    int checks = 0;

    // model state
    logic [9:0]  m_wd    [2];
    logic [1:0]  m_wreg  [2];
    logic [63:0] m_wdata [2];
    logic [31:0] m_hi    [2];
    logic [31:0] m_lo    [2];
    logic        m_whilo [2];
    logic        m_waw   [2];
    int          m_cnt   [2];
    int          stg     [2] = '{4, 5};
    int          cmax    [2] = '{65535, 3};

    always #5 clk = ~clk;

    pipe_wb_reg #(.LANES(2), .STAGE(4), .STALL_W(6), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo),
        .out_wd(o_wd[0]), .out_wreg(o_wreg[0]), .out_wdata(o_wdata[0]),
        .out_hi(o_hi[0]), .out_lo(o_lo[0]), .out_whilo(o_whilo[0]),
        .out_waw(o_waw[0]), .bubble_cnt(cnt0)
    );

    pipe_wb_reg #(.LANES(2), .STAGE(5), .STALL_W(6), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo),
        .out_wd(o_wd[1]), .out_wreg(o_wreg[1]), .out_wdata(o_wdata[1]),
        .out_hi(o_hi[1]), .out_lo(o_lo[1]), .out_whilo(o_whilo[1]),
        .out_waw(o_waw[1]), .bubble_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_nop(input int k);
        m_wd[k] = '0; m_wreg[k] = '0; m_wdata[k] = '0;
        m_hi[k] = '0; m_lo[k] = '0; m_whilo[k] = 1'b0; m_waw[k] = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            model_nop(k);
            m_cnt[k] = 0;
        end
    endtask

    // One rising edge, computed from the rules: flush > bubble > hold > advance.
    task automatic model_step(input int k);
        int   s    = stg[k];
        logic own  = stall[s];
        logic down = (s < 5) ? stall[s+1] : 1'b0;
        if (flush)
            model_nop(k);
        else if (own && !down) begin
            model_nop(k);
            if (m_cnt[k] < cmax[k]) m_cnt[k]++;
        end else if (!own) begin
            m_wd[k]    = in_wd;
            m_wreg[k]  = in_wreg;
            m_wdata[k] = in_wdata;
            m_hi[k]    = in_hi;
            m_lo[k]    = in_lo;
            m_whilo[k] = in_whilo;
            m_waw[k]   = (in_wreg == 2'b11) && (in_wd[4:0] == in_wd[9:5]) && (in_wd[4:0] != 5'd0);
        end
        if (cnt_clr) m_cnt[k] = 0;
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.d%0d.wd", ph, k),    64'(o_wd[k]),    64'(m_wd[k]));
            chk($sformatf("%s.d%0d.wreg", ph, k),  64'(o_wreg[k]),  64'(m_wreg[k]));
            chk($sformatf("%s.d%0d.wdata", ph, k), o_wdata[k],      m_wdata[k]);
            chk($sformatf("%s.d%0d.hi", ph, k),    64'(o_hi[k]),    64'(m_hi[k]));
            chk($sformatf("%s.d%0d.lo", ph, k),    64'(o_lo[k]),    64'(m_lo[k]));
            chk($sformatf("%s.d%0d.whilo", ph, k), 64'(o_whilo[k]), 64'(m_whilo[k]));
            chk($sformatf("%s.d%0d.waw", ph, k),   64'(o_waw[k]),   64'(m_waw[k]));
        end
        chk({ph, ".d0.cnt"}, 64'(cnt0), 64'(m_cnt[0]));
        chk({ph, ".d1.cnt"}, 64'(cnt1), 64'(m_cnt[1]));
    endtask

    // Inputs are changed just after a negedge. The edge updates both DUTs and the model,
    // and the outputs are compared at the following negedge.
    task automatic cyc(input string ph);
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic set_bundle(input logic [9:0] wd, input logic [1:0] wr, input logic [63:0] wdat);
        in_wd = wd; in_wreg = wr; in_wdata = wdat;
        in_hi = $urandom; in_lo = $urandom; in_whilo = 1'($urandom);
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 0; cnt_clr = 0;
        in_wd = '0; in_wreg = '0; in_wdata = '0; in_hi = '0; in_lo = '0; in_whilo = 0;
        model_reset();
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // advance: lane0 writes 0x1234 to r3
        set_bundle(10'd3, 2'b01, 64'h0000_0000_0000_1234);
        stall = 6'b000000;
        cyc("adv");
        chk("adv.wd0", 64'(o_wd[0][4:0]), 64'd3);
        chk("adv.wdata0", 64'(o_wdata[0][31:0]), 64'h1234);
        chk("adv.wreg0", 64'(o_wreg[0][0]), 64'd1);

        // bubble x3 on stage 4 (stage 5 advances)
        stall = 6'b010000;
        for (int i = 0; i < 3; i++) cyc("bub");
        chk("bub.cnt3", 64'(cnt0), 64'd3);

        // load a bundle, then hold stage 4 for 5 cycles (stage 5 bubbles and saturates at 3)
        stall = 6'b000000;
        set_bundle({5'd9, 5'd9}, 2'b11, 64'hdead_beef_0bad_f00d);
        cyc("load");
        stall = 6'b110000;
        set_bundle(10'h3ff, 2'b10, 64'h1111_2222_3333_4444);
        for (int i = 0; i < 5; i++) cyc("hold");
        chk("hold.waw", 64'(o_waw[0]), 64'd1);
        chk("hold.cnt", 64'(cnt0), 64'd3);
        chk("sat.cnt1", 64'(cnt1), 64'd3);

        // reset asserted between edges while holding: outputs drop immediately
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("rst_mid");
        #1 rst = 1'b1;
        cyc("post_rst");

        // WAW: same nonzero register -> 1, register 0 -> 0
        stall = 6'b000000;
        set_bundle({5'd7, 5'd7}, 2'b11, 64'h5);
        cyc("waw7");
        chk("waw7.flag", 64'(o_waw[0]), 64'd1);
        set_bundle({5'd0, 5'd0}, 2'b11, 64'h6);
        cyc("waw0");
        chk("waw0.flag", 64'(o_waw[0]), 64'd0);

        // priority: one real bubble, then flush over bubble (not counted), then clear over bubble
        stall = 6'b010000;
        cyc("pri_bub");
        flush = 1;
        cyc("pri_flush");
        chk("pri_flush.cnt", 64'(cnt0), 64'd1);
        flush = 0; cnt_clr = 1;
        cyc("pri_clr");
        chk("pri_clr.cnt", 64'(cnt0), 64'd0);
        cnt_clr = 0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            stall   = 6'($urandom);
            flush   = ($urandom_range(0, 7) == 0);
            cnt_clr = ($urandom_range(0, 15) == 0);
            set_bundle({5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
                       2'($urandom), {$urandom, $urandom});
            cyc("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
